// File: rtl/laplace_line_buffer.sv
// Raster pixel stream to vertical 3-pixel columns (rows n-2, n-1, n)
// using two line memories; valid/ack handshake on both sides.
module laplace_line_buffer #(
  parameter int IMG_WIDTH = 512,
  parameter int COL_W     = 9
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_pixel,
  input  logic       i_sof,
  input  logic       i_pixel_valid,
  output logic       o_pixel_ack,
  output logic [7:0] o_pixel_1,
  output logic [7:0] o_pixel_2,
  output logic [7:0] o_pixel_3,
  output logic       o_pixel_valid,
  input  logic       i_pixel_ack
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

  logic [7:0]       r_line_a [IMG_WIDTH];
  logic [7:0]       r_line_b [IMG_WIDTH];
  logic [COL_W-1:0] r_col;
  logic [1:0]       r_row_cnt;
  logic             r_valid;
  logic [7:0]       r_pix_1;
  logic [7:0]       r_pix_2;
  logic [7:0]       r_pix_3;

  logic             w_accept;
  logic             w_primed;
  logic             w_last;
  logic [COL_W-1:0] w_c;
  logic [1:0]       w_row;
  logic [1:0]       w_row_inc;
  logic [7:0]       w_a;
  logic [7:0]       w_b;

  assign o_pixel_ack   = (~r_valid | i_pixel_ack) & ~i_rst;
  assign w_accept      = i_pixel_valid & o_pixel_ack;
  assign w_c           = i_sof ? '0 : r_col;
  assign w_row         = i_sof ? 2'd0 : r_row_cnt;
  assign w_row_inc     = (w_row == 2'd2) ? 2'd2 : w_row + 2'd1;
  assign w_last        = (w_c == LAST_COL);
  assign w_primed      = (r_row_cnt == 2'd2) & ~i_sof;
  assign w_a           = r_line_a[w_c];
  assign w_b           = r_line_b[w_c];

  assign o_pixel_1     = r_pix_1;
  assign o_pixel_2     = r_pix_2;
  assign o_pixel_3     = r_pix_3;
  assign o_pixel_valid = r_valid;

  // Line memories: async read, so the old column is shifted down before overwrite
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_line_b[w_c] <= w_a;
      r_line_a[w_c] <= i_pixel;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col     <= '0;
      r_row_cnt <= 2'd0;
      r_valid   <= 1'b0;
      r_pix_1   <= 8'd0;
      r_pix_2   <= 8'd0;
      r_pix_3   <= 8'd0;
    end else begin
      if (w_accept) begin
        r_col     <= w_last ? '0 : w_c + COL_W'(1);
        r_row_cnt <= w_last ? w_row_inc : w_row;
      end
      if (w_accept && w_primed) begin
        r_pix_1 <= w_b;
        r_pix_2 <= w_a;
        r_pix_3 <= i_pixel;
        r_valid <= 1'b1;
      end else if (i_pixel_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_laplace_line_buffer.sv
// Scoreboard bench for laplace_line_buffer with a 4-pixel-wide image.
module tb_laplace_line_buffer;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_pixel;
  logic       i_sof;
  logic       i_pixel_valid;
  logic       o_pixel_ack;
  logic [7:0] o_pixel_1;
  logic [7:0] o_pixel_2;
  logic [7:0] o_pixel_3;
  logic       o_pixel_valid;
  logic       i_pixel_ack;

  int passed = 0;
  int total  = 0;
  bit rand_ack = 1'b0;

  logic [23:0] exp_q[$];
  logic [7:0]  fr [5][W];

  laplace_line_buffer #(.IMG_WIDTH(W), .COL_W(2)) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_pixel(i_pixel),
    .i_sof(i_sof),
    .i_pixel_valid(i_pixel_valid),
    .o_pixel_ack(o_pixel_ack),
    .o_pixel_1(o_pixel_1),
    .o_pixel_2(o_pixel_2),
    .o_pixel_3(o_pixel_3),
    .o_pixel_valid(o_pixel_valid),
    .i_pixel_ack(i_pixel_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rand_ack) begin
      #1;
      i_pixel_ack = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: a column transfers at the next rising edge
  always @(negedge clk) begin
    if (!i_rst && o_pixel_valid && i_pixel_ack) begin
      logic [23:0] got;
      logic [23:0] e;
      got = {o_pixel_1, o_pixel_2, o_pixel_3};
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL column: unexpected %h, none expected", got);
      end else begin
        e = exp_q.pop_front();
        if (got === e) passed++;
        else $display("FAIL column: got %h want %h", got, e);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, req);
  endtask

  task automatic push(input int a, input int b, input int c);
    exp_q.push_back({8'(a), 8'(b), 8'(c)});
  endtask

  task automatic send(input logic [7:0] p, input logic sof, input int gap);
    int n;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    i_pixel_valid = 1'b1;
    i_pixel       = p;
    i_sof         = sof;
    n = 0;
    forever begin
      @(negedge clk);
      if (o_pixel_ack) break;
      n++;
      if (n > 50) begin
        total++;
        $display("FAIL accept timeout: pixel %0h not taken in 50 cycles", p);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    i_pixel_valid = 1'b0;
    i_sof         = 1'b0;
  endtask

  initial begin
    int n;
    i_rst         = 1'b1;
    i_pixel       = 8'hAA;
    i_sof         = 1'b0;
    i_pixel_valid = 1'b1;
    i_pixel_ack   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst valid", 32'(o_pixel_valid), 0);
    check("rst ack", 32'(o_pixel_ack), 0);
    check("rst pix1", 32'(o_pixel_1), 0);
    check("rst pix2", 32'(o_pixel_2), 0);
    check("rst pix3", 32'(o_pixel_3), 0);
    @(posedge clk);
    #1;
    i_rst         = 1'b0;
    i_pixel_valid = 1'b0;
    @(negedge clk);
    check("ack after rst", 32'(o_pixel_ack), 1);
    @(posedge clk);
    #1;

    // Rows 0..3, back-to-back
    push(0, 4, 8);
    push(1, 5, 9);
    push(2, 6, 10);
    push(3, 7, 11);
    push(4, 8, 12);
    push(5, 9, 13);
    push(6, 10, 14);
    push(7, 11, 15);
    for (int i = 0; i < 16; i++) send(8'(i), i == 0, 0);

    // Backpressure on column (8,12,16)
    push(8, 12, 16);
    send(8'd16, 1'b0, 0);
    i_pixel_ack   = 1'b0;
    i_pixel_valid = 1'b1;
    i_pixel       = 8'd17;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp valid", 32'(o_pixel_valid), 1);
      check("bp ack", 32'(o_pixel_ack), 0);
      check("bp column", {8'd0, o_pixel_1, o_pixel_2, o_pixel_3},
            {8'd0, 8'd8, 8'd12, 8'd16});
      @(posedge clk);
      #1;
    end
    push(9, 13, 17);
    i_pixel_ack = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    i_pixel_valid = 1'b0;
    push(10, 14, 18);
    push(11, 15, 19);
    send(8'd18, 1'b0, 0);
    send(8'd19, 1'b0, 0);

    // Mid-row restart at column 2
    push(12, 16, 20);
    push(13, 17, 21);
    send(8'd20, 1'b0, 0);
    send(8'd21, 1'b0, 0);
    for (int i = 0; i < 8; i++) send(8'(100 + i), i == 0, 0);
    push(100, 104, 108);
    push(101, 105, 109);
    push(102, 106, 110);
    push(103, 107, 111);
    for (int i = 8; i < 12; i++) send(8'(100 + i), 1'b0, 0);

    // Random valid gaps and ack toggling over 3 frames
    rand_ack = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < W; c++) begin
          fr[r][c] = 8'($urandom_range(0, 255));
          if (r >= 2) push(int'(fr[r-2][c]), int'(fr[r-1][c]), int'(fr[r][c]));
          send(fr[r][c], r == 0 && c == 0, $urandom_range(0, 2));
        end
      end
    end
    rand_ack = 1'b0;
    @(posedge clk);
    #1;
    i_pixel_ack = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("queue drained", 32'(exp_q.size()), 0);
    check("idle valid", 32'(o_pixel_valid), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/laplace_line_buffer.md
Name: laplace_line_buffer

Overview:
- Upstream neighbour of the 3x3 Laplace column filter.
- Converts a raster-order 8-bit pixel stream into vertical 3-pixel columns (rows n-2, n-1, n) using two internal line memories, one column per accepted input pixel.
- Output uses the same valid/ack handshake the filter consumes. The filter forwards its ack straight to this block's output ack.

Parameters:
- IMG_WIDTH, 512, pixels per image row (line memory depth); must be >= 2.
- COL_W, 9, column counter / memory address width; must satisfy 2^COL_W >= IMG_WIDTH.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_pixel  input  8  incoming raster pixel.
- i_sof  input  1  start of frame; qualified by i_pixel_valid, marks the pixel at row 0, col 0.
- i_pixel_valid  input  1  upstream pixel valid.
- o_pixel_ack  output  1  ready to upstream; transfer when i_pixel_valid & o_pixel_ack.
- o_pixel_1  output  8  column pixel from row n-2 (top).
- o_pixel_2  output  8  column pixel from row n-1 (middle).
- o_pixel_3  output  8  column pixel from row n (current, bottom).
- o_pixel_valid  output  1  column valid to downstream.
- i_pixel_ack  input  1  downstream ready; transfer when o_pixel_valid & i_pixel_ack.

Behaviour:
- Reset (i_rst=1 at clock edge):
  - o_pixel_valid=0; o_pixel_1/2/3=0; col=0; row_cnt=0.
  - Line memory contents are not reset; they are don't-care and masked by priming.
  - Reset mid-frame discards the frame. The next accepted pixel is treated as row 0, col 0.
- o_pixel_ack = ~o_pixel_valid | i_pixel_ack (combinational). Never asserted during i_rst.
- Accept = i_pixel_valid & o_pixel_ack. On accept at column c (c = 0 if i_sof, else col):
  - lineB[c] <= lineA[c]; lineA[c] <= i_pixel.
  - Memories use asynchronous read (distributed RAM); read-before-write within the same cycle.
  - If primed: o_pixel_1 <= lineB[c], o_pixel_2 <= lineA[c], o_pixel_3 <= i_pixel, o_pixel_valid <= 1. Latency is one cycle from accept to o_pixel_valid.
  - If not primed: outputs unchanged. o_pixel_valid <= 0 if the current output is consumed this cycle, else it holds.
- Column counter:
  - col <= c+1; when c == IMG_WIDTH-1, col <= 0 and row_cnt <= min(row_cnt+1, 2).
  - i_sof forces c=0 and row_cnt to 0 before the increment logic. A mid-row i_sof restarts the frame.
- Priming: primed = (row_cnt == 2) and i_sof not asserted on this pixel. Rows 0 and 1 of every frame produce no output. Each row from row 2 onward produces IMG_WIDTH columns.
- Output hold: while o_pixel_valid=1 and i_pixel_ack=0, o_pixel_1/2/3 and o_pixel_valid hold and o_pixel_ack=0, so no accept occurs.
- Simultaneous consume and accept: the new column replaces the old in the same edge, so back-to-back throughput is 1 column/cycle. Consume with no accept sets o_pixel_valid <= 0.
- No column wrap-around masking: edge columns are passed through. Border handling belongs downstream.

Test Plan:
- Reset: IMG_WIDTH=4; assert i_rst with i_pixel_valid=1 -> o_pixel_valid=0, o_pixel_ack=0, outputs 0; deassert -> o_pixel_ack=1.
- Priming: IMG_WIDTH=4, i_sof on first pixel, stream values 0..11, i_pixel_ack=1 -> no valid for pixels 0..7. Pixel 8 gives (0,4,8) one cycle after accept; pixels 9..11 give (1,5,9), (2,6,10), (3,7,11).
- Continued row: feed pixels 12..15 after the above -> columns (4,8,12) through (7,11,15); 1 column/cycle, no gaps.
- Backpressure: hold i_pixel_ack=0 for 3 cycles while a column is valid -> outputs stable, o_pixel_ack=0, no pixel lost. Release -> next column follows with the correct values.
- Mid-row restart: after 2 primed rows, assert i_sof at col 2 -> no output for the next 2 rows; the following row emits columns starting at col 0 with new-frame data.
- Random valid/ack: random i_pixel_valid and i_pixel_ack toggling over 3 frames vs. scoreboard model -> every emitted column matches exactly, in order, with none dropped or duplicated.
